// File: rtl/rr_mux_arbiter.sv
// N:1 valid/ready merge stage with a registered output and round-robin channel selection.
// Define RR_MUX_ARBITER_FIXED_PRIO_EN for lowest-index-first selection, which drops the pointer.
module rr_mux_arbiter #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   in_valid_i,
    input  logic [N*W-1:0] in_data_i,
    output logic [N-1:0]   in_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic [CW-1:0]  out_chan_o,
    input  logic           out_ready_i
);

    logic [N-1:0][W-1:0] in_data_arr;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_data_q,  out_data_d;
    logic [CW-1:0]       out_chan_q,  out_chan_d;
    logic [CW-1:0]       sel;
    logic                any_valid;
    logic                can_accept;
    logic                push;

    assign in_data_arr = in_data_i;
    assign any_valid   = |in_valid_i;
    assign can_accept  = !out_valid_q || out_ready_i;
    assign push        = can_accept && any_valid;
    assign in_ready_o  = push ? (N'(1) << sel) : '0;

`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid_i[k]) sel = CW'(k);
        end
    end
`else
    logic [CW-1:0] ptr_q, ptr_d;

    // Scan from ptr upward, wrapping; the first valid channel wins.
    always_comb begin
        logic found;
        int   idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && in_valid_i[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) ptr_d = (int'(sel) + 1 >= N) ? '0 : CW'(int'(sel) + 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (push) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_arr[sel];
            out_chan_d  = sel;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the merge stage.
module tb_rr_mux_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_chan;
    logic           out_ready;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: what the output register holds and where the next search starts.
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_chan  = 0;
    int m_ptr   = 0;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_chan_o (out_chan),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int s;
        s = pick(in_valid, m_ptr);
        if ((!m_valid || out_ready) && s >= 0) return N'(1) << s;
        return '0;
    endfunction

    always @(posedge clk) begin
        int s;
        s = pick(in_valid, m_ptr);
        if (rst) begin
            m_valid = 1'b0; m_data = 0; m_chan = 0; m_ptr = 0;
        end else if ((!m_valid || out_ready) && s >= 0) begin
            m_valid = 1'b1;
            m_data  = int'(in_data[s*W +: W]);
            m_chan  = s;
            m_ptr   = (s + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m.in_ready",  in_ready,  exp_ready());
            check("m.out_valid", out_valid, m_valid);
            check("m.out_data",  out_data,  m_data);
            check("m.out_chan",  out_chan,  m_chan);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d);
        in_data[ch*W +: W] = d;
    endtask

    int exp_seq[6];

    initial begin
        rst = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ch(i, 8'h10 + W'(i));

        // Reset held two cycles with all channels requesting.
        step(); step();
        @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_data",  out_data,  0);
        check("rst.out_chan",  out_chan,  0);
        chk_en = 1'b1;

        // Release: first grant is channel 0, then rotation with no bubbles.
        step(); rst = 1'b0;
        @(negedge clk);
        check("rst.first_grant", in_ready, 4'b0001);
`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check("fair.out_valid", out_valid, 1);
            check("fair.out_chan",  out_chan,  exp_seq[i]);
        end

        // Reset together with a transfer.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.grant",     in_ready,  4'b0001);
        step();
        @(negedge clk);
        check("midrst.out_chan", out_chan, 0);
        step(); in_valid = '0;
        step();
        @(negedge clk);
        check("drain.out_valid", out_valid, 0);

        // Single channel.
        in_valid = 4'b0100; set_ch(2, 8'hA5);
        @(negedge clk);
        check("single.in_ready", in_ready, 4'b0100);
        step();
        @(negedge clk);
        check("single.out_valid", out_valid, 1);
        check("single.out_data",  out_data,  8'hA5);
        check("single.out_chan",  out_chan,  2);

        // Load 0x11 from channel 1 (pointer now at 2), then stall for three cycles.
        in_valid = 4'b0010; set_ch(1, 8'h11);
        step();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.in_ready", in_ready, 0);
            check("bp.out_data", out_data, 8'h11);
            check("bp.out_chan", out_chan, 1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
        check("bp.resume_grant", in_ready, 4'b0001);
`else
        check("bp.resume_grant", in_ready, 4'b0100);
`endif

        // Pop and push in the same cycle, then drain.
        step();
        in_valid = 4'b0010; set_ch(1, 8'h3C);
        step();
        @(negedge clk);
        check("pp.out_valid", out_valid, 1);
        check("pp.out_data",  out_data,  8'h3C);
        check("pp.out_chan",  out_chan,  1);
        in_valid = '0;
        step();
        @(negedge clk);
        check("pp.drain", out_valid, 0);

        // Random traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid  = N'($urandom_range(0, (1 << N) - 1));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 127) == 0);
        end
        step(); rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
